// File: rtl/adder_sequencer_if.sv
// Request/response bundle between the two requesters, the consumer and adder_sequencer.
// The sequencer is the slave; whatever drives the requests and drains the responses is the master.
interface adder_sequencer_if;
   logic [1:0] reqValid;
   logic [1:0] reqReady;
   logic [1:0] reqOp0;
   logic [1:0] reqOp1;
   logic [5:0] reqA0;
   logic [5:0] reqA1;
   logic [5:0] reqB0;
   logic [5:0] reqB1;
   logic       rspValid;
   logic       rspReady;
   logic       rspId;
   logic [5:0] rspZ;
   logic       rspCarry;
   logic       rspOverflow;
   logic       busy;

   modport slave (
      input  reqValid, reqOp0, reqOp1, reqA0, reqA1, reqB0, reqB1, rspReady,
      output reqReady, rspValid, rspId, rspZ, rspCarry, rspOverflow, busy
   );

   modport master (
      output reqValid, reqOp0, reqOp1, reqA0, reqA1, reqB0, reqB1, rspReady,
      input  reqReady, rspValid, rspId, rspZ, rspCarry, rspOverflow, busy
   );
endinterface

// File: rtl/adder_sequencer.sv
// Round-robin front end that time-shares one 6-bit ripple-carry adder across two requesters.
// It runs ADD/SUB/INC in one pass and MUL as six shift-add passes.
module adder_sequencer #(
   parameter bit MUL_ENABLE    = 1'b1,
   parameter bit PRIORITY_INIT = 1'b0
) (
   input logic               clk,
   input logic               resetN,
   adder_sequencer_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MUL  = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_INC = 2'd3;

   logic [1:0] r_state;
   logic       r_lastGrant;
   logic [1:0] r_op;
   logic [5:0] r_a;
   logic [5:0] r_b;
   logic       r_id;
   logic [5:0] r_acc;
   logic       r_lost;
   logic [2:0] r_cnt;
   logic       r_rspValid;
   logic [5:0] r_rspZ;
   logic       r_rspCarry;
   logic       r_rspOverflow;

   logic [1:0] w_grant;
   logic [1:0] w_reqReady;
   logic       w_accept;
   logic       w_acceptId;
   logic [1:0] w_selOp;
   logic [5:0] w_selA;
   logic [5:0] w_selB;
   logic [5:0] w_addA;
   logic [5:0] w_addB;
   logic       w_addCin;
   logic [6:0] w_carry;
   logic [5:0] w_sum;
   logic       w_cout;
   logic       w_ovf;
   logic [5:0] w_mulAcc;
   logic       w_mulLost;

   // r_lastGrant names the requester served last, so a tie goes to the other one.
   always_comb begin
      w_grant = 2'b00;
      case (bus.reqValid)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_lastGrant ? 2'b01 : 2'b10;
         default: w_grant = 2'b00;
      endcase
   end

   assign w_reqReady = ((r_state == S_IDLE) && resetN) ? w_grant : 2'b00;
   assign w_accept   = |w_reqReady;
   assign w_acceptId = w_reqReady[1];
   assign w_selOp    = w_acceptId ? bus.reqOp1 : bus.reqOp0;
   assign w_selA     = w_acceptId ? bus.reqA1  : bus.reqA0;
   assign w_selB     = w_acceptId ? bus.reqB1  : bus.reqB0;

   // During MUL the operand registers double as multiplicand (r_a) and multiplier (r_b).
   always_comb begin
      w_addA   = r_a;
      w_addB   = r_b;
      w_addCin = 1'b0;
      if (r_state == S_MUL) begin
         w_addA = r_acc;
         w_addB = r_a;
      end else begin
         case (r_op)
            OP_SUB: begin
               w_addB   = ~r_b;
               w_addCin = 1'b1;
            end
            OP_INC: begin
               w_addB   = 6'd0;
               w_addCin = 1'b1;
            end
            default: begin
               w_addB   = r_b;
               w_addCin = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_carry    = 7'd0;
      w_sum      = 6'd0;
      w_carry[0] = w_addCin;
      for (int i = 0; i < 6; i++) begin
         w_sum[i]     = w_addA[i] ^ w_addB[i] ^ w_carry[i];
         w_carry[i+1] = (w_addA[i] & w_addB[i]) | (w_addA[i] & w_carry[i]) | (w_addB[i] & w_carry[i]);
      end
   end

   assign w_cout = w_carry[6];
   assign w_ovf  = w_carry[6] ^ w_carry[5];

   // A set multiplicand MSB about to be shifted out still matters if any multiplier bit remains.
   assign w_mulAcc  = r_b[0] ? w_sum : r_acc;
   assign w_mulLost = r_lost | (r_b[0] & w_cout) | (r_a[5] & (r_b[5:1] != 5'd0));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state       <= S_IDLE;
         r_lastGrant   <= ~PRIORITY_INIT;
         r_op          <= OP_ADD;
         r_a           <= 6'd0;
         r_b           <= 6'd0;
         r_id          <= 1'b0;
         r_acc         <= 6'd0;
         r_lost        <= 1'b0;
         r_cnt         <= 3'd0;
         r_rspValid    <= 1'b0;
         r_rspZ        <= 6'd0;
         r_rspCarry    <= 1'b0;
         r_rspOverflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op        <= w_selOp;
                  r_a         <= w_selA;
                  r_b         <= w_selB;
                  r_id        <= w_acceptId;
                  r_lastGrant <= w_acceptId;
                  r_acc       <= 6'd0;
                  r_lost      <= 1'b0;
                  r_cnt       <= 3'd0;
                  r_state     <= ((w_selOp == OP_MUL) && MUL_ENABLE) ? S_MUL : S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_op == OP_MUL) begin
                  r_rspZ        <= 6'd0;
                  r_rspCarry    <= 1'b0;
                  r_rspOverflow <= 1'b1;
               end else begin
                  r_rspZ        <= w_sum;
                  r_rspCarry    <= w_cout;
                  r_rspOverflow <= w_ovf;
               end
               r_rspValid <= 1'b1;
               r_state    <= S_RESP;
            end
            S_MUL: begin
               r_acc  <= w_mulAcc;
               r_lost <= w_mulLost;
               r_a    <= {r_a[4:0], 1'b0};
               r_b    <= {1'b0, r_b[5:1]};
               r_cnt  <= r_cnt + 3'd1;
               if (r_cnt == 3'd5) begin
                  r_rspZ        <= w_mulAcc;
                  r_rspCarry    <= 1'b0;
                  r_rspOverflow <= w_mulLost;
                  r_rspValid    <= 1'b1;
                  r_state       <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.rspReady) begin
                  r_rspValid <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.reqReady    = w_reqReady;
   assign bus.rspValid    = r_rspValid;
   assign bus.rspId       = r_id;
   assign bus.rspZ        = r_rspZ;
   assign bus.rspCarry    = r_rspCarry;
   assign bus.rspOverflow = r_rspOverflow;
   assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: table vectors and random ops checked through a response scoreboard,
// plus hand sequences for arbitration, backpressure, reset mid-MUL and the MUL-disabled build.
module tb_adder_sequencer;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_INC = 2'd3;

   typedef struct {
      logic       id;
      logic [5:0] z;
      logic       c;
      logic       v;
   } rsp_t;

   typedef struct {
      logic       id;
      logic [1:0] op;
      logic [5:0] a;
      logic [5:0] b;
      logic [5:0] z;
      logic       c;
      logic       v;
      int         lat;
   } vec_t;

   logic clk    = 1'b0;
   logic resetN = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   rsp_t expQ[$];

   adder_sequencer_if busIf();
   adder_sequencer_if busNoMul();

   adder_sequencer #(.MUL_ENABLE(1'b1), .PRIORITY_INIT(1'b0)) dut (
      .clk(clk), .resetN(resetN), .bus(busIf)
   );

   adder_sequencer #(.MUL_ENABLE(1'b0), .PRIORITY_INIT(1'b1)) dutNoMul (
      .clk(clk), .resetN(resetN), .bus(busNoMul)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no end of test, expected finish before 100000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Arithmetic reference written from the integer meaning of each op, not from the adder structure.
   function automatic rsp_t refModel(input logic id, input logic [1:0] op, input logic [5:0] a, input logic [5:0] b);
      rsp_t r;
      int   s;
      r.id = id;
      r.z  = 6'd0;
      r.c  = 1'b0;
      r.v  = 1'b0;
      case (op)
         OP_ADD: begin
            s   = int'(a) + int'(b);
            r.z = 6'(s);
            r.c = (s >= 64);
            r.v = (a[5] == b[5]) && (r.z[5] != a[5]);
         end
         OP_SUB: begin
            s   = int'(a) + 64 - int'(b);
            r.z = 6'(s);
            r.c = (s >= 64);
            r.v = (a[5] != b[5]) && (r.z[5] != a[5]);
         end
         OP_INC: begin
            s   = int'(a) + 1;
            r.z = 6'(s);
            r.c = (s >= 64);
            r.v = (a == 6'd31);
         end
         default: begin
            s   = int'(a) * int'(b);
            r.z = 6'(s);
            r.v = (s >= 64);
         end
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      if (resetN && busIf.rspValid && busIf.rspReady) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedRsp: got response z=%0d id=%0d, expected none", busIf.rspZ, busIf.rspId);
         end else begin
            rsp_t e;
            e = expQ.pop_front();
            checkOutput("rspId", busIf.rspId, e.id);
            checkOutput("rspZ", busIf.rspZ, e.z);
            checkOutput("rspCarry", busIf.rspCarry, e.c);
            checkOutput("rspOverflow", busIf.rspOverflow, e.v);
         end
      end
   end

   task automatic setReq(input logic id, input logic [1:0] op, input logic [5:0] a, input logic [5:0] b);
      if (id) begin
         busIf.reqOp1 = op;
         busIf.reqA1  = a;
         busIf.reqB1  = b;
      end else begin
         busIf.reqOp0 = op;
         busIf.reqA0  = a;
         busIf.reqB0  = b;
      end
   endtask

   task automatic waitAccept(input logic id, input rsp_t e, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (busIf.reqReady[id]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL acceptTimeout: got no reqReady for requester %0d, expected a grant", id);
      end else begin
         @(posedge clk);
         expQ.push_back(e);
      end
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      rsp_t e;
      bit   ok;
      int   n;
      e.id = v.id;
      e.z  = v.z;
      e.c  = v.c;
      e.v  = v.v;
      setReq(v.id, v.op, v.a, v.b);
      busIf.reqValid[v.id] = 1'b1;
      waitAccept(v.id, e, ok);
      busIf.reqValid[v.id] = 1'b0;
      if (ok) begin
         n = 0;
         while (n < 20) begin
            @(negedge clk);
            n++;
            if (busIf.rspValid) break;
         end
         checkOutput("latency", n, v.lat);
         @(posedge clk);
         #1;
      end
   endtask

   // Both requesters hold ADDs; grants must alternate starting at requester 0, one accept per 3 cycles.
   task automatic runArbitration(input int count);
      int   lastAcc;
      bit   got;
      logic gId;
      rsp_t e;
      lastAcc = 0;
      busIf.reqValid = 2'b11;
      for (int k = 0; k < count; k++) begin
         got = 1'b0;
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busIf.reqReady != 2'b00) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL arbTimeout: got reqReady 0, expected a grant for accept %0d", k);
            break;
         end
         gId = busIf.reqReady[1];
         checkOutput("arbGrant", busIf.reqReady, (k % 2 == 0) ? 1 : 2);
         e = gId ? refModel(1'b1, busIf.reqOp1, busIf.reqA1, busIf.reqB1)
                 : refModel(1'b0, busIf.reqOp0, busIf.reqA0, busIf.reqB0);
         @(posedge clk);
         expQ.push_back(e);
         #1;
         if (k > 0) checkOutput("arbSpacing", cycle - lastAcc, 3);
         lastAcc = cycle;
         if (k == count - 1) busIf.reqValid = 2'b00;
      end
      busIf.reqValid = 2'b00;
   endtask

   task automatic waitDrain();
      for (int n = 0; n < 40 && expQ.size() != 0; n++) @(posedge clk);
      #1;
      checkOutput("drain", expQ.size(), 0);
   endtask

   task automatic doReset();
      resetN = 1'b0;
      expQ.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      resetN = 1'b1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "ReqReady"}, busIf.reqReady, 0);
      checkOutput({tag, "RspValid"}, busIf.rspValid, 0);
      checkOutput({tag, "RspId"}, busIf.rspId, 0);
      checkOutput({tag, "RspZ"}, busIf.rspZ, 0);
      checkOutput({tag, "RspCarry"}, busIf.rspCarry, 0);
      checkOutput({tag, "RspOverflow"}, busIf.rspOverflow, 0);
      checkOutput({tag, "Busy"}, busIf.busy, 0);
   endtask

   initial begin
      vec_t       vecs[13];
      vec_t       rv;
      rsp_t       r;
      logic [1:0] rop;
      logic [5:0] ra;
      logic [5:0] rb;
      logic       rid;
      int         n;

      vecs[0]  = '{1'b0, OP_ADD, 6'd20, 6'd30, 6'd50, 1'b0, 1'b1, 2};
      vecs[1]  = '{1'b1, OP_SUB, 6'd5,  6'd7,  6'd62, 1'b0, 1'b0, 2};
      vecs[2]  = '{1'b0, OP_INC, 6'd63, 6'd17, 6'd0,  1'b1, 1'b0, 2};
      vecs[3]  = '{1'b1, OP_MUL, 6'd7,  6'd9,  6'd63, 1'b0, 1'b0, 7};
      vecs[4]  = '{1'b0, OP_MUL, 6'd8,  6'd8,  6'd0,  1'b0, 1'b1, 7};
      vecs[5]  = '{1'b1, OP_MUL, 6'd33, 6'd2,  6'd2,  1'b0, 1'b1, 7};
      vecs[6]  = '{1'b0, OP_ADD, 6'd63, 6'd1,  6'd0,  1'b1, 1'b0, 2};
      vecs[7]  = '{1'b1, OP_SUB, 6'd32, 6'd1,  6'd31, 1'b1, 1'b1, 2};
      vecs[8]  = '{1'b0, OP_SUB, 6'd7,  6'd7,  6'd0,  1'b1, 1'b0, 2};
      vecs[9]  = '{1'b1, OP_MUL, 6'd0,  6'd63, 6'd0,  1'b0, 1'b0, 7};
      vecs[10] = '{1'b0, OP_MUL, 6'd63, 6'd1,  6'd63, 1'b0, 1'b0, 7};
      vecs[11] = '{1'b1, OP_MUL, 6'd2,  6'd32, 6'd0,  1'b0, 1'b1, 7};
      vecs[12] = '{1'b0, OP_ADD, 6'd31, 6'd1,  6'd32, 1'b0, 1'b1, 2};

      busIf.reqValid = 2'b00;
      busIf.rspReady = 1'b1;
      setReq(1'b0, OP_ADD, 6'd0, 6'd0);
      setReq(1'b1, OP_ADD, 6'd0, 6'd0);
      busNoMul.reqValid = 2'b00;
      busNoMul.rspReady = 1'b1;
      busNoMul.reqOp0 = OP_ADD;
      busNoMul.reqA0  = 6'd0;
      busNoMul.reqB0  = 6'd0;
      busNoMul.reqOp1 = OP_ADD;
      busNoMul.reqA1  = 6'd0;
      busNoMul.reqB1  = 6'd0;

      $display("[TB] reset state");
      busIf.reqValid = 2'b11;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      busIf.reqValid = 2'b00;
      @(posedge clk);
      #1;
      resetN = 1'b1;

      $display("[TB] vector table");
      for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

      $display("[TB] random operations");
      for (int i = 0; i < 12; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = 6'($urandom_range(0, 63));
         rb  = 6'($urandom_range(0, 63));
         rid = 1'($urandom_range(0, 1));
         r   = refModel(rid, rop, ra, rb);
         rv  = '{rid, rop, ra, rb, r.z, r.c, r.v, (rop == OP_MUL) ? 7 : 2};
         applyStimulus(rv);
      end
      waitDrain();

      $display("[TB] arbitration");
      doReset();
      setReq(1'b0, OP_ADD, 6'd1, 6'd2);
      setReq(1'b1, OP_ADD, 6'd10, 6'd20);
      runArbitration(4);
      waitDrain();

      $display("[TB] backpressure");
      busIf.rspReady = 1'b0;
      setReq(1'b0, OP_ADD, 6'd3, 6'd4);
      busIf.reqValid[0] = 1'b1;
      waitAccept(1'b0, refModel(1'b0, OP_ADD, 6'd3, 6'd4), rv.c);
      busIf.reqValid[0] = 1'b0;
      setReq(1'b1, OP_ADD, 6'd5, 6'd5);
      busIf.reqValid[1] = 1'b1;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (busIf.rspValid) break;
      end
      checkOutput("bpLatency", n, 2);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput("bpRspValid", busIf.rspValid, 1);
         checkOutput("bpRspZ", busIf.rspZ, 7);
         checkOutput("bpRspId", busIf.rspId, 0);
         checkOutput("bpRspCarry", busIf.rspCarry, 0);
         checkOutput("bpRspOverflow", busIf.rspOverflow, 0);
         checkOutput("bpReqReady", busIf.reqReady, 0);
         checkOutput("bpBusy", busIf.busy, 1);
      end
      @(posedge clk);
      #1;
      busIf.rspReady = 1'b1;
      busIf.reqValid = 2'b00;
      @(posedge clk);
      #1;
      checkOutput("bpIdleBusy", busIf.busy, 0);
      checkOutput("bpIdleRspValid", busIf.rspValid, 0);
      waitDrain();

      $display("[TB] reset during MUL");
      setReq(1'b0, OP_MUL, 6'd7, 6'd9);
      busIf.reqValid[0] = 1'b1;
      waitAccept(1'b0, refModel(1'b0, OP_MUL, 6'd7, 6'd9), rv.c);
      setReq(1'b0, OP_ADD, 6'd1, 6'd1);
      setReq(1'b1, OP_ADD, 6'd2, 6'd2);
      busIf.reqValid = 2'b11;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("midMulBusy", busIf.busy, 1);
      resetN = 1'b0;
      expQ.delete();
      #1;
      checkAllZero("midMul");
      @(posedge clk);
      @(posedge clk);
      #1;
      resetN = 1'b1;
      runArbitration(2);
      waitDrain();
      applyStimulus(vecs[3]);
      waitDrain();

      $display("[TB] MUL disabled build");
      busNoMul.reqOp0 = OP_ADD;
      busNoMul.reqA0  = 6'd1;
      busNoMul.reqB0  = 6'd1;
      busNoMul.reqOp1 = OP_MUL;
      busNoMul.reqA1  = 6'd7;
      busNoMul.reqB1  = 6'd9;
      busNoMul.reqValid = 2'b11;
      @(negedge clk);
      checkOutput("noMulTieGrant", busNoMul.reqReady, 2);
      @(posedge clk);
      #1;
      busNoMul.reqValid = 2'b00;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (busNoMul.rspValid) break;
      end
      checkOutput("noMulLatency", n, 2);
      checkOutput("noMulRspZ", busNoMul.rspZ, 0);
      checkOutput("noMulRspCarry", busNoMul.rspCarry, 0);
      checkOutput("noMulRspOverflow", busNoMul.rspOverflow, 1);
      checkOutput("noMulRspId", busNoMul.rspId, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("noMulIdle", busNoMul.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Shared-adder controller for the 6-bit ripple-carry adder datapath. Two requesters submit operations over valid/ready handshakes. A round-robin arbiter grants one request at a time, and the block sequences the single adder instance to perform ADD, SUB, INC or a 6-cycle shift-add MUL. It returns a registered result with carry and overflow flags over a response handshake.

## Interface
- MUL_ENABLE, 1, 1 = MUL op implemented; 0 = MUL op returns an error response.
- PRIORITY_INIT, 0, requester that wins the first tie after reset (0 or 1).

- clk  in  1  single clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- reqValid  in  2  bit i = requester i has a request pending.
- reqReady  out  2  bit i = request i accepted this cycle (one-hot or zero).
- reqOp0, reqOp1  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 INC.
- reqA0, reqA1  in  6  operand A per requester.
- reqB0, reqB1  in  6  operand B per requester (ignored for INC).
- rspValid  out  1  response registers hold a valid result.
- rspReady  in  1  consumer accepts the response.
- rspId  out  1  requester that issued the response.
- rspZ  out  6  result.
- rspCarry  out  1  adder carry-out (ADD/SUB/INC); 0 for MUL.
- rspOverflow  out  1  signed overflow (ADD/SUB/INC); unsigned product ≥ 64 (MUL).
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, MUL, RESP. Reset state is IDLE.
- On reset, every output is 0 and the round-robin pointer is loaded so that PRIORITY_INIT wins the next tie.
- IDLE:
  - reqReady[i] = grant[i]. Grant is combinational from reqValid.
  - If only one request is valid, that requester is granted.
  - If both are valid, the requester not granted last is granted.
- Acceptance is the edge where reqValid[i] & reqReady[i]. On acceptance:
  - Latch op, A, B and id.
  - Update the pointer.
  - Go to MUL if op = MUL and MUL_ENABLE = 1; otherwise go to EXEC.
- EXEC drives the adder once, then registers the result and goes to RESP:
  - ADD: adder(a, b, carryIn = 0).
  - SUB: adder(a, ~b, carryIn = 1). rspCarry = 1 means no borrow.
  - INC: adder(a, 0, carryIn = 1).
  - rspCarry and rspOverflow come straight from the adder.
  - If op = MUL and MUL_ENABLE = 0: rspZ = 0, rspCarry = 0, rspOverflow = 1.
- MUL runs exactly 6 iterations, counted by a 3-bit counter from 0 to 5.
  - Registers: acc = 0, mcand = a, mplier = b, lost = 0.
  - Each iteration:
    - If mplier[0] = 1: acc = adder(acc, mcand, 0), and lost is set if carryOut = 1.
    - If mcand[5] = 1 and (mplier >> 1) ≠ 0: lost is set.
    - Then mcand <<= 1 and mplier >>= 1.
  - After iteration 5: rspZ = acc, rspCarry = 0, rspOverflow = lost. Go to RESP.
- RESP:
  - rspValid = 1. rspId, rspZ and the flags are held stable.
  - On rspValid & rspReady, go to IDLE and drop rspValid on the next cycle.
- reqReady is 0 in every state except IDLE. There is no request queuing; requesters hold reqValid and their operands until accepted.
- All arithmetic is 6-bit modulo 64. No flag depends on bits beyond bit 5 except through adder carryOut.

## Timing
- Acceptance at edge T.
- ADD/SUB/INC (and MUL with MUL_ENABLE = 0): EXEC during cycle T+1, rspValid = 1 from cycle T+2.
- MUL: iterations in cycles T+1 to T+6, rspValid = 1 from cycle T+7.
- If rspReady is 1 at the edge ending cycle R, the FSM is in IDLE in cycle R+1 and the earliest next acceptance is at the end of R+1.
- Minimum spacing between acceptances: 3 cycles for ADD/SUB/INC, 8 cycles for MUL.
- Response backpressure: the FSM stays in RESP indefinitely and holds all rsp outputs stable. Both reqReady bits stay 0.
- Both requesters valid every cycle: grants alternate 0, 1, 0, 1 …, starting with PRIORITY_INIT.
- A request withdrawn before acceptance (reqValid falls while reqReady = 0) is legal. Withdrawing after acceptance has no effect.
- Reset asserted mid-EXEC, mid-MUL or mid-RESP:
  - Immediately (asynchronously) returns to IDLE, with all outputs 0 and the pointer reinitialised.
  - The in-flight result is discarded.

## Test plan
- Single ADD: req0 = (ADD, 20, 30) -> rspZ = 50, rspCarry = 0, rspOverflow = 1, rspId = 0, rspValid 2 cycles after accept.
- SUB and INC wrap: req1 = (SUB, 5, 7) -> rspZ = 62, rspCarry = 0, rspOverflow = 0; req0 = (INC, 63, x) -> rspZ = 0, rspCarry = 1, rspOverflow = 0.
- MUL: (MUL, 7, 9) -> rspZ = 63, rspOverflow = 0 at 7 cycles; (MUL, 8, 8) -> rspZ = 0, rspOverflow = 1; (MUL, 33, 2) -> rspZ = 2, rspOverflow = 1. With MUL_ENABLE = 0: rspZ = 0, rspOverflow = 1 at 2 cycles.
- Arbitration: both requesters hold reqValid with ADD operations, rspReady = 1, PRIORITY_INIT = 0 -> rspId sequence 0, 1, 0, 1, with an accept every 3 cycles.
- Backpressure: rspReady = 0 for 10 cycles after rspValid -> rsp outputs stable, reqReady = 00, busy = 1; rspReady = 1 -> IDLE on the next cycle.
- Reset mid-MUL: resetN = 0 at iteration 3 -> all outputs 0 immediately; after release, a tie is granted to PRIORITY_INIT and new requests complete correctly.
